fp_mul_sched: RTL and testbench
===============================

FP_MUL_SCHED -- requirements
Module: fp_mul_sched

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- EXP, 8, exponent bits.
- MAN, 23, mantissa bits.
- BITS, MAN+EXP+1, word width.
- BIAS, 2**(EXP-1)-1, exponent bias.
- NREQ, 4, requester count.
- LAT, 2, multiplier pipeline depth (LAT >= 1).

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, all state on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- req_valid, in, NREQ, per-requester operation request.
- req_x, in, NREQ x BITS, operand X per requester.
- req_y, in, NREQ x BITS, operand Y per requester.
- req_ready, out, NREQ, one-hot grant/accept.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts result.
- res_id, out, $clog2(NREQ), requester index of the result.
- res_data, out, BITS, product.
- res_flags, out, 5, {inf, nan, zero, overflow, underflow}.
- busy, out, 1, state != IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, MUL and RESP; exactly one operation is in flight at any time.
REQ-004 In IDLE with any req_valid set, the block SHALL assert req_ready for exactly one requester (combinational, that cycle only), register its operands and index, and move to MUL.
REQ-005 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates on every accept.
REQ-006 req_ready SHALL be all-zero in MUL and RESP, and in IDLE when no req_valid is set.
REQ-007 In MUL, the block SHALL assert in_valid to the core for one cycle and wait for out_valid, which arrives exactly LAT cycles later; it SHALL then register the result and flags and move to RESP.
REQ-008 In RESP, res_valid=1 and res_id, res_data and res_flags SHALL hold stable until res_ready=1; on that handshake the FSM SHALL move to IDLE.
REQ-009 The earliest regrant SHALL be the cycle after the RESP handshake; with res_ready held high, sustained throughput is one operation per LAT+3 cycles.
REQ-010 Multiply semantics SHALL be as follows.
- Sign: XOR of operand signs.
- Exponent: Xe+Ye-BIAS, plus 1 when the mantissa product is >= 2.
- Mantissa: truncated, no rounding.
- Special-case priority: zero > nan > inf > underflow > overflow.
- On zero or underflow, res_data = 0.
- On nan, inf or overflow, res_data = {0, all-ones exponent, 0 mantissa}.
REQ-011 A requester dropping req_valid before being granted SHALL lose nothing; a granted operation SHALL always complete.
REQ-012 When several requesters are valid simultaneously, exactly one SHALL be granted; the others SHALL remain pending without side effects.

Reset
REQ-013 Asserting reset_n low SHALL immediately force the FSM to IDLE and last_grant to NREQ-1 (so requester 0 wins first), clear all outputs to 0 and flush the core pipeline.
REQ-014 A reset arriving mid-MUL or mid-RESP SHALL discard the operation; no res_valid appears for it after reset release.

Configuration
REQ-015 With macro FPMUL_STICKY_EN defined, the block SHALL add the following ports:
- input sticky_clr (1 bit).
- output sticky_flags (5 bits), the OR of res_flags over every completed RESP handshake.
- Clear behaviour: sticky_clr clears the register; when sticky_clr coincides with a handshake, the new flags are kept.
- Reset value: 0.
REQ-016 Without FPMUL_STICKY_EN, those ports and that register SHALL NOT exist.

Structure
REQ-017 A shared package fp_mul_pkg SHALL hold the following.
- The FSM state enum.
- A flags struct {inf, nan, zero, overflow, underflow}.
- Default EXP/MAN/BIAS constants.
REQ-018 Sub-module fp_mul_pipe SHALL contain the REQ-010 multiply followed by LAT register stages, with in_valid/out_valid; fp_mul_sched contains the FSM, the arbiter and the output register.

Verification
REQ-019 The bench SHALL cover the following directed scenarios.
- Req0 x=0x40000000, y=0x40400000 -> res_data=0x40C00000, flags=0, res_id=0, res_valid LAT+2 cycles after grant.
- Req1 x=0x3FC00000, y=0x3FC00000 -> res_data=0x40100000 (normalization path).
- Req2 x=0x00000000, y=0x3F800000 -> res_data=0, flags=00100; req3 x=0x7F800000, y=0x3F800000 -> 0x7F800000, flags=10000.
- All four req_valid held high, res_ready=1 -> grant order 0,1,2,3,0.
- res_ready low for 5 cycles in RESP -> outputs stable, req_ready=0 throughout.
- reset_n pulsed low during MUL -> res_valid stays 0, next grant goes to req0.
- With FPMUL_STICKY_EN: the zero op followed by the inf op -> sticky_flags=10100; sticky_clr -> 0.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: FSM state, result-flag layout and default binary32 format constants
// shared by the FP multiply scheduler and its multiply pipeline.
package fp_mul_pkg;

    localparam int FP_EXP_DEF  = 8;
    localparam int FP_MAN_DEF  = 23;
    localparam int FP_BIAS_DEF = 2 ** (FP_EXP_DEF - 1) - 1;
    localparam int FLAGS_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Field order gives the packed layout {inf, nan, zero, overflow, underflow}.
    typedef struct packed {
        logic inf;
        logic nan;
        logic zero;
        logic overflow;
        logic underflow;
    } flags_t;

    function automatic flags_t flags_clear();
        return '0;
    endfunction

endpackage

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: truncating floating-point multiply with one-hot special-case flags,
// followed by LAT register stages; out_valid follows in_valid by exactly LAT cycles.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP  = FP_EXP_DEF,
    parameter int MAN  = FP_MAN_DEF,
    parameter int BITS = MAN + EXP + 1,
    parameter int BIAS = 2 ** (EXP - 1) - 1,
    parameter int LAT  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid_i,
    input  logic [BITS-1:0] x_i,
    input  logic [BITS-1:0] y_i,
    output logic            out_valid_o,
    output logic [BITS-1:0] data_o,
    output flags_t          flags_o
);

    localparam int EW = EXP + 2;
    localparam int PW = 2 * (MAN + 1);
    localparam logic [EXP-1:0]       EXP_MAX = '1;
    localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);

    logic                 x_sign, y_sign;
    logic [EXP-1:0]       x_exp, y_exp;
    logic [MAN-1:0]       x_man, y_man;
    logic [PW-1:0]        prod;
    logic                 norm;
    logic [MAN-1:0]       man_c;
    logic signed [EW-1:0] exp_c;
    logic [BITS-1:0]      data_c;
    flags_t               flags_c;

    assign {x_sign, x_exp, x_man} = x_i;
    assign {y_sign, y_exp, y_man} = y_i;

    // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        flags_c = flags_clear();
        prod    = {{(MAN + 1){1'b0}}, 1'b1, x_man} * {{(MAN + 1){1'b0}}, 1'b1, y_man};
        norm    = prod[PW-1];
        man_c   = norm ? MAN'(prod >> (MAN + 1)) : MAN'(prod >> MAN);
        exp_c   = $signed({2'b00, x_exp}) + $signed({2'b00, y_exp}) - BIAS_S
                + $signed({{(EW - 1){1'b0}}, norm});
        data_c  = {x_sign ^ y_sign, exp_c[EXP-1:0], man_c};

        if (x_exp == '0 || y_exp == '0) begin
            flags_c.zero = 1'b1;
        end else if ((x_exp == EXP_MAX && x_man != '0) || (y_exp == EXP_MAX && y_man != '0)) begin
            flags_c.nan = 1'b1;
        end else if (x_exp == EXP_MAX || y_exp == EXP_MAX) begin
            flags_c.inf = 1'b1;
        end else if (exp_c[EW-1] || exp_c == '0) begin
            flags_c.underflow = 1'b1;
        end else if (exp_c >= $signed({2'b00, EXP_MAX})) begin
            flags_c.overflow = 1'b1;
        end

        if (flags_c.zero || flags_c.underflow) begin
            data_c = '0;
        end else if (flags_c.nan || flags_c.inf || flags_c.overflow) begin
            data_c = {1'b0, EXP_MAX, {MAN{1'b0}}};
        end
    end

    logic   [LAT-1:0]           vld_q;
    logic   [LAT-1:0][BITS-1:0] data_q;
    flags_t [LAT-1:0]           flags_q;

    // NOTE: state registers use non-blocking assignments so every stage samples the previous stage's old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            data_q  <= '0;
            flags_q <= '0;
        end else begin
            vld_q[0]   <= in_valid_i;
            data_q[0]  <= data_c;
            flags_q[0] <= flags_c;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                data_q[i]  <= data_q[i-1];
                flags_q[i] <= flags_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[LAT-1];
    assign data_o      = data_q[LAT-1];
    assign flags_o     = flags_q[LAT-1];

endmodule

// File: rtl/fp_mul_sched.sv
// fp_mul_sched: round-robin arbiter feeding one shared FP multiply pipeline, one op in flight.
// Optional FPMUL_STICKY_EN adds sticky_clr / sticky_flags accumulating flags of delivered results.
module fp_mul_sched
    import fp_mul_pkg::*;
#(
    parameter int EXP  = FP_EXP_DEF,
    parameter int MAN  = FP_MAN_DEF,
    parameter int BITS = MAN + EXP + 1,
    parameter int BIAS = 2 ** (EXP - 1) - 1,
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0][BITS-1:0] req_x,
    input  logic [NREQ-1:0][BITS-1:0] req_y,
    output logic [NREQ-1:0]           req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [IDW-1:0]            res_id,
    output logic [BITS-1:0]           res_data,
    output logic [FLAGS_W-1:0]        res_flags,
    output logic                      busy
`ifdef FPMUL_STICKY_EN
    ,
    input  logic                      sticky_clr,
    output logic [FLAGS_W-1:0]        sticky_flags
`endif
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [BITS-1:0] x_q, x_d;
    logic [BITS-1:0] y_q, y_d;
    logic            issued_q, issued_d;
    logic [BITS-1:0] data_q, data_d;
    flags_t          flags_q, flags_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;

    logic            mul_start;
    logic            pipe_valid;
    logic [BITS-1:0] pipe_data;
    flags_t          pipe_flags;

    // Round-robin search: first valid requester after last_q, wrapping at NREQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = last_q;
        for (int i = 0; i < NREQ; i++) begin
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        x_d       = x_q;
        y_d       = y_q;
        issued_d  = issued_q;
        data_d    = data_q;
        flags_d   = flags_q;
        req_ready = '0;
        mul_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    last_d   = grant_idx;
                    id_d     = grant_idx;
                    x_d      = req_x[grant_idx];
                    y_d      = req_y[grant_idx];
                    issued_d = 1'b0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                // Issue exactly once; the result returns LAT cycles later.
                if (!issued_q) begin
                    mul_start = 1'b1;
                    issued_d  = 1'b1;
                end
                if (pipe_valid) begin
                    data_d  = pipe_data;
                    flags_d = pipe_flags;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= IDW'(NREQ - 1);
            id_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            issued_q <= 1'b0;
            data_q   <= '0;
            flags_q  <= flags_clear();
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            x_q      <= x_d;
            y_q      <= y_d;
            issued_q <= issued_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
        end
    end

    fp_mul_pipe #(
        .EXP  (EXP),
        .MAN  (MAN),
        .BITS (BITS),
        .BIAS (BIAS),
        .LAT  (LAT)
    ) u_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (mul_start),
        .x_i         (x_q),
        .y_i         (y_q),
        .out_valid_o (pipe_valid),
        .data_o      (pipe_data),
        .flags_o     (pipe_flags)
    );

    assign res_valid = (state_q == RESP);
    assign res_id    = id_q;
    assign res_data  = data_q;
    assign res_flags = flags_q;
    assign busy      = (state_q != IDLE);

`ifdef FPMUL_STICKY_EN
    logic [FLAGS_W-1:0] sticky_q, sticky_d;

    // A clear coinciding with a handshake still keeps the flags being delivered.
    always_comb begin
        sticky_d = sticky_clr ? '0 : sticky_q;
        if (state_q == RESP && res_ready) begin
            sticky_d = sticky_d | flags_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fp_mul_sched.sv
// tb_fp_mul_sched: directed vector table, hand-written corner sequences, and a randomized
// run scored against a behavioural truncating-multiply and round-robin model.
module tb_fp_mul_sched;

    localparam int LAT      = 2;
    localparam int NREQ     = 4;
    localparam int NV       = 14;
    localparam int RAND_CYC = 3000;
    localparam int DRAIN    = 60;

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] data;
        logic [4:0]  flags;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [4:0]  flags;
        int          gcyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       req_valid;
    logic [3:0][31:0] req_x;
    logic [3:0][31:0] req_y;
    logic [3:0]       req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_id;
    logic [31:0]      res_data;
    logic [4:0]       res_flags;
    logic             busy;
`ifdef FPMUL_STICKY_EN
    logic             sticky_clr;
    logic [4:0]       sticky_flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_mul_sched #(
        .EXP  (8),
        .MAN  (23),
        .NREQ (NREQ),
        .LAT  (LAT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_ready    (req_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_data     (res_data),
        .res_flags    (res_flags),
        .busy         (busy)
`ifdef FPMUL_STICKY_EN
        ,
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Reference multiply from the arithmetic definition: returns {flags, data}.
    function automatic logic [36:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int          xe, ye, e;
        longint      xm, ym, p, m;
        logic [31:0] d;
        logic [4:0]  f;
        xe = int'(x[30:23]);
        ye = int'(y[30:23]);
        xm = longint'(x[22:0]) + (longint'(1) << 23);
        ym = longint'(y[22:0]) + (longint'(1) << 23);
        d  = 32'd0;
        f  = 5'b00000;
        if (xe == 0 || ye == 0) begin
            f = 5'b00100;
        end else if ((xe == 255 && x[22:0] != 0) || (ye == 255 && y[22:0] != 0)) begin
            f = 5'b01000;
        end else if (xe == 255 || ye == 255) begin
            f = 5'b10000;
        end else begin
            p = xm * ym;
            e = xe + ye - 127;
            if (p >= (longint'(1) << 47)) begin
                e = e + 1;
                m = p / (longint'(1) << 24);
            end else begin
                m = p / (longint'(1) << 23);
            end
            if (e <= 0)        f = 5'b00001;
            else if (e >= 255) f = 5'b00010;
            else               d = {x[31] ^ y[31], 8'(e), 23'(m)};
        end
        if (f[4] || f[3] || f[1]) d = 32'h7F80_0000;
        return {f, d};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(7))
            0:       r[30:23] = 8'h00;
            1:       r[30:23] = 8'hFF;
            2, 3, 4: r[30:23] = 8'($urandom_range(100, 154));
            default: ;
        endcase
        return r;
    endfunction

    // Single-requester operation with latency, result and handshake checks.
    task automatic run_op(input int id, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ed, input logic [4:0] ef, input string tag);
        int         k;
        logic [3:0] oh;
        oh        = 4'b0000;
        oh[id]    = 1'b1;
        req_valid = 4'b0000;
        req_valid[id] = 1'b1;
        req_x[id] = x;
        req_y[id] = y;
        res_ready = 1'b0;
        #1;
        k = 0;
        while (req_ready == 4'b0000 && k < 20) begin
            step();
            k++;
        end
        check({tag, " grant"}, req_ready, oh);
        step();
        req_valid = 4'b0000;
        k = 1;
        while (!res_valid && k < 20) begin
            step();
            k++;
        end
        check({tag, " latency"}, k, LAT + 2);
        check({tag, " data"}, res_data, ed);
        check({tag, " flags"}, res_flags, ef);
        check({tag, " id"}, res_id, id);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, " released"}, res_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[NV];
        exp_t        q[$];
        exp_t        e;
        logic [36:0] r;
        logic [3:0]  exp_rdy;
        logic [3:0]  consumed;
        logic        exp_vld;
        int          gid[5];
        int          gcyc[5];
        int          ng, cyc, last_m, g;

        vecs[0]  = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000};
        vecs[1]  = '{1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 5'b00000};
        vecs[2]  = '{2, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 5'b00100};
        vecs[3]  = '{3, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 5'b10000};
        vecs[4]  = '{0, 32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0000, 5'b01000};
        vecs[5]  = '{1, 32'h0000_0000, 32'h7FC0_0000, 32'h0000_0000, 5'b00100};
        vecs[6]  = '{2, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 5'b00100};
        vecs[7]  = '{3, 32'h7FC0_0000, 32'h7F80_0000, 32'h7F80_0000, 5'b01000};
        vecs[8]  = '{0, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 5'b00000};
        vecs[9]  = '{1, 32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 5'b00000};
        vecs[10] = '{2, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 5'b00010};
        vecs[11] = '{3, 32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 5'b00000};
        vecs[12] = '{0, 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 5'b00001};
        vecs[13] = '{1, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 5'b00000};

        reset_n   = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        res_ready = 1'b0;
`ifdef FPMUL_STICKY_EN
        sticky_clr = 1'b0;
`endif
        step();
        step();
        check("reset res_valid", res_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset req_ready", req_ready, 4'b0000);
        check("reset res_data", res_data, 32'h0);
        check("reset res_flags", res_flags, 5'b0);
        check("reset res_id", res_id, 2'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].data, vecs[i].flags,
                   $sformatf("vec%0d", i));
        end

        // Back-pressure: result held for 5 cycles while other requesters wait.
        req_valid = 4'b0010;
        req_x[1]  = 32'h3FC0_0000;
        req_y[1]  = 32'h3FC0_0000;
        res_ready = 1'b0;
        #1;
        check("bp grant", req_ready, 4'b0010);
        step();
        req_valid = 4'b1111;
        g = 0;
        while (!res_valid && g < 20) begin
            step();
            g++;
        end
        check("bp res_valid", res_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp hold valid", res_valid, 1'b1);
            check("bp hold data", res_data, 32'h4010_0000);
            check("bp hold flags", res_flags, 5'b0);
            check("bp hold id", res_id, 2'd1);
            check("bp no grant", req_ready, 4'b0000);
        end
        res_ready = 1'b1;
        step();
        req_valid = 4'b0000;
        res_ready = 1'b0;
        check("bp done", res_valid, 1'b0);

        // Reset while the multiply is in flight discards it.
        req_valid = 4'b0100;
        req_x[2]  = 32'h4000_0000;
        req_y[2]  = 32'h4000_0000;
        #1;
        check("mid grant", req_ready, 4'b0100);
        step();
        check("mid busy", busy, 1'b1);
        req_valid = 4'b0000;
        reset_n   = 1'b0;
        #1;
        check("mid rst busy", busy, 1'b0);
        check("mid rst res_valid", res_valid, 1'b0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            check("mid no result", res_valid, 1'b0);
        end

        // All four requesting with res_ready high: rotation and throughput.
        for (int i = 0; i < NREQ; i++) begin
            req_x[i] = 32'h3F80_0000;
            req_y[i] = 32'h3F80_0000;
        end
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        check("post-reset grant", req_ready, 4'b0001);
        ng  = 0;
        cyc = 0;
        while (ng < 5 && cyc < 100) begin
            if (req_ready != 4'b0000) begin
                for (int b = 0; b < NREQ; b++) if (req_ready[b]) gid[ng] = b;
                gcyc[ng] = cyc;
                ng++;
            end
            step();
            cyc++;
        end
        check("rr grant count", ng, 5);
        last_m = NREQ - 1;
        for (int k = 0; k < ng; k++) begin
            last_m = (last_m + 1) % NREQ;
            check($sformatf("rr order %0d", k), gid[k], last_m);
            if (k > 0) check($sformatf("rr spacing %0d", k), gcyc[k] - gcyc[k-1], LAT + 3);
        end
        do_reset();

`ifdef FPMUL_STICKY_EN
        check("sticky reset", sticky_flags, 5'b0);
        run_op(2, 32'h0000_0000, 32'h3F80_0000, 32'h0, 5'b00100, "sticky zero");
        run_op(3, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 5'b10000, "sticky inf");
        check("sticky accum", sticky_flags, 5'b10100);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky clear", sticky_flags, 5'b0);
        do_reset();
`endif

        // Randomized traffic against the model.
        last_m   = NREQ - 1;
        consumed = '0;
        for (int c = 0; c < RAND_CYC; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (consumed[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else if (c < RAND_CYC - DRAIN && $urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_x[i]     = rand_op();
                    req_y[i]     = rand_op();
                end
            end
            consumed  = '0;
            res_ready = (c >= RAND_CYC - DRAIN) ? 1'b1 : ($urandom_range(2) != 0);
            #1;
            exp_rdy = 4'b0000;
            g = -1;
            if (q.size() == 0 && req_valid != 4'b0000) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && req_valid[(last_m + k) % NREQ]) g = (last_m + k) % NREQ;
                end
                exp_rdy[g] = 1'b1;
            end
            check("rand req_ready", req_ready, exp_rdy);
            exp_vld = (q.size() > 0) && ((c - q[0].gcyc) >= LAT + 2);
            check("rand res_valid", res_valid, exp_vld);
            if (exp_vld && res_ready) begin
                e = q.pop_front();
                check("rand res_id", res_id, e.id);
                check("rand res_data", res_data, e.data);
                check("rand res_flags", res_flags, e.flags);
            end
            if (g >= 0) begin
                r = ref_mul(req_x[g], req_y[g]);
                q.push_back('{g, r[31:0], r[36:32], c});
                last_m      = g;
                consumed[g] = 1'b1;
            end
        end
        check("rand drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
